// File: rtl/poker_types.sv
// Shared card, deck and dealer FSM types for the poker datapath.
package poker_types;

    typedef struct packed {
        logic [3:0] rank;
        logic [1:0] suit;
    } card_t;

    localparam card_t       CARD_NONE     = '0;
    localparam int          DECK_SIZE     = 52;
    localparam logic [15:0] SEED_FALLBACK = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS     = 16'hB400;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INIT,
        ST_SHUFFLE,
        ST_DEAL,
        ST_DONE
    } dealer_state_t;

    // Deck index k -> rank 2..14 (ace high), suit 0..3.
    function automatic card_t idx_to_card(input logic [5:0] idx);
        card_t c;
        c.rank = 4'(idx % 6'd13) + 4'd2;
        c.suit = 2'(idx / 6'd13);
        return c;
    endfunction

    // Smallest all-ones value covering i, so masked draws stay close to the range.
    function automatic logic [5:0] swap_mask(input logic [5:0] i);
        logic [5:0] m;
        if (i > 6'd31)      m = 6'd63;
        else if (i > 6'd15) m = 6'd31;
        else if (i > 6'd7)  m = 6'd15;
        else if (i > 6'd3)  m = 6'd7;
        else if (i > 6'd1)  m = 6'd3;
        else                m = 6'd1;
        return m;
    endfunction

endpackage

// File: rtl/dealer_lfsr.sv
// Right-shifting Galois LFSR used as the shuffle random source.
// A zero seed would lock the register up, so it is replaced by the fallback seed.
module dealer_lfsr #(
    parameter int               LFSR_W        = 16,
    parameter logic [LFSR_W-1:0] SEED_FALLBACK = poker_types::SEED_FALLBACK,
    parameter logic [LFSR_W-1:0] TAPS          = poker_types::LFSR_TAPS
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              load,
    input  logic              enable,
    input  logic [LFSR_W-1:0] seed,
    output logic [LFSR_W-1:0] state
);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= SEED_FALLBACK;
        end else if (load) begin
            state <= (seed == '0) ? SEED_FALLBACK : seed;
        end else if (enable) begin
            state <= {1'b0, state[LFSR_W-1:1]} ^ (state[0] ? TAPS : '0);
        end
    end

endmodule

// File: rtl/card_dealer.sv
// Shuffles a 52-card deck (Fisher-Yates driven by an LFSR) and deals hole and board cards.
// Define DEALER_FIXED_DECK_EN to skip the shuffle and deal the identity deck.
//   state   | meaning
//   IDLE    | waiting for start
//   INIT    | deck loaded with identity order
//   SHUFFLE | one swap attempt per cycle, i from 51 down to 1
//   DEAL    | cards copied from top of deck to outputs
//   DONE    | outputs valid, waiting for next start
module card_dealer
    import poker_types::*;
#(
    parameter int                NUM_PLAYERS   = 2,
    parameter int                LFSR_W        = 16,
    parameter logic [LFSR_W-1:0] SEED_FALLBACK = poker_types::SEED_FALLBACK
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic                              start,
    input  logic [LFSR_W-1:0]                 seed,
    output logic                              busy,
    output logic                              done,
    output card_t [NUM_PLAYERS-1:0][1:0]      player_cards,
    output card_t [2:0]                       flop_card,
    output card_t                             turn_card,
    output card_t                             river_card,
    input  logic [5:0]                        deck_rd_addr,
    output logic [5:0]                        deck_rd_data
);

    localparam int BOARD_BASE = 2 * NUM_PLAYERS;

    dealer_state_t     state, state_nxt;
    logic [5:0]        deck [DECK_SIZE];
    logic [5:0]        idx;
    logic [LFSR_W-1:0] lfsr;
    logic [5:0]        cand;
    logic              accept;
    logic              start_ok;
    logic              lfsr_unused;

    dealer_lfsr #(
        .LFSR_W        (LFSR_W),
        .SEED_FALLBACK (SEED_FALLBACK),
        .TAPS          (LFSR_TAPS)
    ) u_lfsr (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (start_ok),
        .enable  (state == ST_SHUFFLE),
        .seed    (seed),
        .state   (lfsr)
    );

    assign lfsr_unused = ^lfsr[LFSR_W-1:6];
    assign start_ok    = start && (state == ST_IDLE || state == ST_DONE);
    assign cand        = lfsr[5:0] & swap_mask(idx);
    assign accept      = (cand <= idx);
    assign busy        = (state == ST_INIT) || (state == ST_SHUFFLE) || (state == ST_DEAL);
    assign done        = (state == ST_DONE);

    always_ff @(posedge clk) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE, ST_DONE: if (start) state_nxt = ST_INIT;
`ifdef DEALER_FIXED_DECK_EN
            ST_INIT:          state_nxt = ST_DEAL;
`else
            ST_INIT:          state_nxt = ST_SHUFFLE;
`endif
            ST_SHUFFLE:       if (accept && idx == 6'd1) state_nxt = ST_DEAL;
            ST_DEAL:          state_nxt = ST_DONE;
            default:          state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            idx <= 6'd51;
        end else if (start_ok) begin
            idx <= 6'd51;
        end else if (state == ST_SHUFFLE && accept) begin
            idx <= idx - 6'd1;
        end
    end

    // Deck contents are don't-care out of reset; INIT always rebuilds them.
    always_ff @(posedge clk) begin
        if (state == ST_INIT) begin
            for (int c = 0; c < DECK_SIZE; c++) deck[c] <= 6'(c);
        end else if (state == ST_SHUFFLE && accept) begin
            deck[idx]  <= deck[cand];
            deck[cand] <= deck[idx];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            player_cards <= '0;
            flop_card    <= '0;
            turn_card    <= CARD_NONE;
            river_card   <= CARD_NONE;
        end else if (state == ST_DEAL) begin
            for (int s = 0; s < NUM_PLAYERS; s++) begin
                player_cards[s][0] <= idx_to_card(deck[s]);
                player_cards[s][1] <= idx_to_card(deck[NUM_PLAYERS + s]);
            end
            for (int f = 0; f < 3; f++) flop_card[f] <= idx_to_card(deck[BOARD_BASE + f]);
            turn_card  <= idx_to_card(deck[BOARD_BASE + 3]);
            river_card <= idx_to_card(deck[BOARD_BASE + 4]);
        end
    end

    always_comb begin
        deck_rd_data = 6'h3F;
        if (deck_rd_addr < 6'(DECK_SIZE)) deck_rd_data = deck[deck_rd_addr];
    end

endmodule

// File: doc/card_dealer.md
Name: card_dealer

Overview:
- Upstream stage of the poker datapath. It shuffles a 52-card deck with an LFSR-driven Fisher-Yates pass, then presents the dealt hole cards and board cards.
- The hand FSM latches these outputs and forwards them to the display path: player_cards, flop_card, turn_card, river_card.
- One shuffle per hand. Start/busy/done handshake with the hand FSM.

Parameters:
- NUM_PLAYERS, 2, hole-card seats dealt; fixed at 2 to match display/FSM array shapes.
- LFSR_W, 16, width of the Galois LFSR.
- SEED_FALLBACK, 16'hACE1, substituted when seed input is zero.

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous active-low reset
- start  in  1  single-cycle request to shuffle and deal; sampled only in IDLE/DONE
- seed  in  16  LFSR seed, captured on accepted start
- busy  out  1  high from accepted start until DONE entered
- done  out  1  high in DONE (cards valid); cleared on next accepted start
- player_cards  out  card_t[2][2]  hole cards [seat][0..1]
- flop_card  out  card_t[3]  board cards 0..2
- turn_card  out  card_t  board card 3
- river_card  out  card_t  board card 4
- deck_rd_addr  in  6  debug/verification read index 0..51
- deck_rd_data  out  6  deck[deck_rd_addr] card index, combinational read; 6'h3F if addr>51

Behaviour:
- Storage: deck is an array of 52 × 6-bit card indices in flops. Index k maps to rank = k%13 + 2 (2..14, ace=14) and suit = k/13, via package function idx_to_card.
- Reset (reset_n=0 at clk edge): state=IDLE, busy=0, done=0, all card outputs = CARD_NONE (all-zero card_t), deck contents don't-care, lfsr=SEED_FALLBACK. Reset mid-operation aborts immediately with the same values.
- States: IDLE → INIT → SHUFFLE → DEAL → DONE.
- IDLE/DONE + start=1:
  - lfsr loads seed, or SEED_FALLBACK if seed==0; i=51.
  - busy=1 and done=0 from the next cycle; go to INIT.
- INIT: writes deck[c]=c for c=0..51 in a single cycle (parallel load), then goes to SHUFFLE.
- SHUFFLE:
  - LFSR: Galois, taps 16'hB400, shifts right every SHUFFLE cycle.
  - Candidate r = lfsr[5:0] & mask(i), where mask(i) = smallest 2^n−1 ≥ i.
  - If r ≤ i: swap deck[i] and deck[r] in the same cycle, then i−1.
  - If r > i: reject and draw again next cycle; i is unchanged.
  - When i==1 and the swap is accepted → DEAL. i=0 is never processed.
- DEAL (1 cycle): assigns deal order from the top of the deck:
  - player_cards[0][0]=deck[0], [1][0]=deck[1], [0][1]=deck[2], [1][1]=deck[3]
  - flop=deck[4..6], turn=deck[7], river=deck[8]
  - No burn cards.
- DONE: busy=0, done=1; outputs held until the next accepted start or reset.
- Card outputs hold their previous values through INIT/SHUFFLE. Consumers must qualify them with done.
- start while busy=1: ignored, no effect.
- start in the same cycle DONE is entered: ignored; it is accepted only once state==DONE.
- Latency: start → done = 1 (INIT) + 51 accepted swaps + rejections + 1 (DEAL) + 1. Minimum 54 cycles; bounded in practice, mean rejection rate <50%.
- Output uniqueness invariant: the 9 dealt cards are pairwise distinct. The deck is always a permutation of 0..51 after INIT.

Optional Feature:
- DEALER_FIXED_DECK_EN defined: SHUFFLE is skipped (INIT → DEAL). The deck stays in identity order, giving deterministic demos and display bring-up. start → done = 3 cycles.
- Undefined: normal LFSR shuffle as above.

Decomposition:
- poker_types package holds:
  - card_t (rank[3:0], suit[1:0])
  - CARD_NONE, DECK_SIZE=52, SEED_FALLBACK, LFSR_TAPS
  - dealer_state_t enum
  - function idx_to_card
- One natural sub-module: dealer_lfsr (load, enable, seed → 16-bit state) holding the Galois LFSR and the zero-seed substitution.

Test Plan:
- Reset check: assert reset_n=0 for 2 cycles → busy=0, done=0, all card outputs = CARD_NONE.
- DEALER_FIXED_DECK_EN, start: done after 3 cycles. player_cards[0][0]={2,suit0}, [1][0]={3,0}, [0][1]={4,0}, [1][1]={5,0}; flop={6,0},{7,0},{8,0}; turn={9,0}; river={10,0}.
- Normal mode, seed=16'h1234, start:
  - done within 300 cycles.
  - deck_rd_data over addr 0..51 is a permutation of 0..51.
  - The 9 dealt cards are distinct and equal deck[0..8] mapped through idx_to_card.
  - A rerun with the same seed gives an identical deck.
- Seed equivalence: seed=0 → deck identical to a run with seed=16'hACE1. Seed=16'h0001 → deck differs from both.
- Reset mid-operation: pulse start, wait 20 cycles, then reset_n=0 for 1 cycle → busy=0, done=0, outputs CARD_NONE; a subsequent start completes normally.
- Busy handling: start held high throughout a shuffle → exactly one shuffle runs. done rises once. After done, a fresh start pulse re-enters busy within 1 cycle with done=0.
